// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the DSP48A1-based dot-product sequencer.
package dsp_mac_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // DSP48A1 opmodes: X=M (multiplier), Z=0 or Z=P.
  localparam logic [7:0] OPM_LOAD = 8'h01;  // P = A*B
  localparam logic [7:0] OPM_ACC  = 8'h09;  // P = P + A*B

  // Default DSP pipeline latencies (A1REG=B1REG=MREG=PREG=1, OPMODEREG=1).
  localparam int DSP_LAT_DEF = 3;
  localparam int OPM_DLY_DEF = 1;

  // Datapath widths.
  localparam int OP_W  = 18;
  localparam int P_W   = 48;
  localparam int LEN_W = 8;
  localparam int CNT_W = 8;

endpackage : dsp_mac_pkg

// File: rtl/dsp_mac_dly.sv
// Fixed-depth delay line; used to align the opmode with the deeper
// operand pipeline inside the DSP slice.
module dsp_mac_dly #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift the input through DEPTH register stages.
      // NOTE: every stage is reset so the DSP sees opmode 0 straight after
      // reset; this array is a handful of flops, not a RAM, so a reset costs
      // nothing and keeps X out of the slice.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule : dsp_mac_dly

// File: rtl/dsp_mac_seq.sv
// Dot-product sequencer: streams sample pairs into an external DSP48A1,
// waits for its pipeline to drain, and returns the 48-bit accumulated sum.
module dsp_mac_seq
  import dsp_mac_pkg::*;
#(
  parameter int DSP_LAT = DSP_LAT_DEF,
  parameter int OPM_DLY = OPM_DLY_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [LEN_W-1:0]       len_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic signed [OP_W-1:0] s_a_i,
  input  logic signed [OP_W-1:0] s_b_i,
  output logic signed [OP_W-1:0] dsp_a_o,
  output logic signed [OP_W-1:0] dsp_b_o,
  output logic [7:0]             dsp_opmode_o,
  output logic                   dsp_ce_o,
  output logic                   dsp_rst_o,
  input  logic signed [P_W-1:0]  dsp_p_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic signed [P_W-1:0]  r_data_o,
  output logic                   busy_o
);

  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DSP_LAT);

  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [CNT_W-1:0]       drain_q, drain_d;
  logic                   first_q, first_d;   // first sample of the run already sent
  logic signed [P_W-1:0]  r_data_q, r_data_d;
  logic [7:0]             opm_d;

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      drain_q  <= '0;
      first_q  <= 1'b0;
      r_data_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      drain_q  <= drain_d;
      first_q  <= first_d;
      r_data_q <= r_data_d;
    end
  end

  // Next-state, counters, and DSP operand/opmode selection.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    drain_d  = drain_q;
    first_d  = first_q;
    r_data_d = r_data_q;
    opm_d    = 8'h00;
    dsp_a_o  = '0;
    dsp_b_o  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i && (len_i != '0)) begin
          state_d = ST_RUN;
          rem_d   = len_i;
          first_d = 1'b0;
        end
      end

      ST_RUN: begin
        // Before the first sample the opmode is irrelevant; LOAD of zero is harmless.
        opm_d = first_q ? OPM_ACC : OPM_LOAD;
        if (s_valid_i) begin
          dsp_a_o = s_a_i;
          dsp_b_o = s_b_i;
          first_d = 1'b1;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end
      end

      ST_DRAIN: begin
        opm_d = OPM_ACC;
        // The last product reaches P when the count would step to zero.
        if (drain_q <= CNT_W'(1)) begin
          drain_d  = '0;
          r_data_d = dsp_p_i;
          state_d  = ST_DONE;
        end else begin
          drain_d = drain_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        opm_d = OPM_ACC;
        if (r_ready_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // The opmode register in the slice is one stage shallower than the operand
  // path (A1 + M), so the opmode is presented OPM_DLY cycles late.
  dsp_mac_dly #(
    .WIDTH (8),
    .DEPTH (OPM_DLY)
  ) u_opm_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (opm_d),
    .q_o   (dsp_opmode_o)
  );

  assign s_ready_o = (state_q == ST_RUN);
  assign r_valid_o = (state_q == ST_DONE);
  assign r_data_o  = r_data_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign dsp_ce_o  = (state_q != ST_IDLE);
  assign dsp_rst_o = (state_q == ST_IDLE);

endmodule : dsp_mac_seq

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq: a behavioural DSP48A1 (A1/B1, M, OPMODE, P
// registers, synchronous reset) closes the loop; expected sums are queued
// when a run starts and compared when the result handshake completes.
module tb_dsp_mac_seq;
  import dsp_mac_pkg::*;

  localparam int LAT = DSP_LAT_DEF;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [7:0]             len = '0;
  logic                   s_valid = 1'b0;
  logic                   s_ready;
  logic signed [17:0]     s_a = '0;
  logic signed [17:0]     s_b = '0;
  logic signed [17:0]     dsp_a;
  logic signed [17:0]     dsp_b;
  logic [7:0]             dsp_opmode;
  logic                   dsp_ce;
  logic                   dsp_rst;
  logic signed [47:0]     dsp_p;
  logic                   r_valid;
  logic                   r_ready = 1'b0;
  logic signed [47:0]     r_data;
  logic                   busy;

  int total = 0;
  int bad   = 0;
  logic signed [47:0] exp_q [$];
  int sa [4];
  int sb [4];

  always #5 clk = ~clk;

  dsp_mac_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .len_i        (len),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .s_a_i        (s_a),
    .s_b_i        (s_b),
    .dsp_a_o      (dsp_a),
    .dsp_b_o      (dsp_b),
    .dsp_opmode_o (dsp_opmode),
    .dsp_ce_o     (dsp_ce),
    .dsp_rst_o    (dsp_rst),
    .dsp_p_i      (dsp_p),
    .r_valid_o    (r_valid),
    .r_ready_i    (r_ready),
    .r_data_o     (r_data),
    .busy_o       (busy)
  );

  // DSP48A1 responder model.
  logic signed [17:0] a1_q, b1_q;
  logic signed [35:0] m_q;
  logic [7:0]         opmr_q;
  logic signed [47:0] p_q;
  logic signed [47:0] x_mux, z_mux;

  assign x_mux = (opmr_q[1:0] == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'sd0;
  assign z_mux = (opmr_q[3:2] == 2'b10) ? p_q : 48'sd0;
  assign dsp_p = p_q;

  always_ff @(posedge clk) begin
    if (dsp_rst) begin
      a1_q <= '0; b1_q <= '0; m_q <= '0; opmr_q <= '0; p_q <= '0;
    end else if (dsp_ce) begin
      a1_q   <= dsp_a;
      b1_q   <= dsp_b;
      m_q    <= a1_q * b1_q;
      opmr_q <= dsp_opmode;
      p_q    <= x_mux + z_mux;
    end
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $display("FAIL %s: observed=timeout expected=event", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_busy"},    busy,       0);
    check({pfx, "_s_ready"}, s_ready,    0);
    check({pfx, "_r_valid"}, r_valid,    0);
    check({pfx, "_r_data"},  r_data,     0);
    check({pfx, "_dsp_a"},   dsp_a,      0);
    check({pfx, "_dsp_b"},   dsp_b,      0);
    check({pfx, "_opmode"},  dsp_opmode, 0);
    check({pfx, "_ce"},      dsp_ce,     0);
    check({pfx, "_rst"},     dsp_rst,    1);
  endtask

  // Queue the expected sum of the first n pairs and pulse START.
  task automatic begin_run(input int n);
    logic signed [47:0] sum;
    sum = 0;
    for (int i = 0; i < n; i++) sum = sum + 48'(sa[i] * sb[i]);
    exp_q.push_back(sum);
    start = 1'b1;
    len   = 8'(n);
    step();
    start = 1'b0;
    len   = '0;
  endtask

  // Send the first n pairs, with gap idle cycles before each one after the first.
  task automatic feed(input int n, input int gap, output bit ready_dropped);
    int w;
    ready_dropped = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          s_valid = 1'b0;
          #1;
          if (!s_ready) ready_dropped = 1'b1;
          step();
        end
      end
      s_valid = 1'b1;
      s_a = 18'(sa[i]);
      s_b = 18'(sb[i]);
      #1;
      w = 0;
      while (!s_ready && w < 20) begin
        step();
        w++;
      end
      if (w >= 20) timeout("feed_ready");
      step();
    end
    s_valid = 1'b0;
    s_a = '0;
    s_b = '0;
  endtask

  // Wait for R_VALID, optionally stall hold cycles (START pulsed mid-stall),
  // compare against the scoreboard, then complete the handshake.
  task automatic collect(input string tag, input int hold, input bit start_at_hs);
    int waited;
    bit unstable;
    logic signed [47:0] held;
    logic signed [47:0] expv;
    waited = 0;
    unstable = 1'b0;
    while (!r_valid && waited < 60) begin
      step();
      waited++;
    end
    if (!r_valid) begin
      timeout({tag, "_r_valid"});
      return;
    end
    held = r_data;
    for (int h = 0; h < hold; h++) begin
      r_ready = 1'b0;
      start   = (h == 2);
      len     = (h == 2) ? 8'd2 : 8'd0;
      step();
      start = 1'b0;
      if (r_data !== held || !r_valid) unstable = 1'b1;
    end
    if (hold > 0) check({tag, "_stable"}, unstable, 0);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: observed=%0h expected=none queued", tag, r_data);
    end else begin
      expv = exp_q.pop_front();
      check(tag, r_data, expv);
    end
    r_ready = 1'b1;
    if (start_at_hs) begin
      start = 1'b1;
      len   = 8'd2;
    end
    step();
    r_ready = 1'b0;
    start   = 1'b0;
    len     = '0;
    check({tag, "_idle_busy"},  busy,    0);
    check({tag, "_idle_valid"}, r_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dropped;
    int lat;

    // Reset state.
    step();
    check_reset("rst0");
    rst_n = 1'b1;
    step();

    // LEN=1, (5,6): latency and value.
    sa[0] = 5; sb[0] = 6;
    begin_run(1);
    s_valid = 1'b1; s_a = 18'sd5; s_b = 18'sd6;
    #1;
    check("t1_s_ready", s_ready, 1);
    check("t1_dsp_a", dsp_a, 5);
    check("t1_dsp_b", dsp_b, 6);
    step();
    s_valid = 1'b0; s_a = '0; s_b = '0;
    #1;
    check("t1_opm_load", dsp_opmode, OPM_LOAD);
    check("t1_drain_ready", s_ready, 0);
    check("t1_drain_a0", dsp_a, 0);
    lat = 1;
    while (!r_valid && lat < 20) begin
      step();
      lat++;
    end
    check("t1_latency", lat, LAT + 1);
    collect("t1_sum", 0, 0);

    // LEN=3 back-to-back: 200 + 30 - 21 = 209.
    sa[0] = 20; sb[0] = 10;
    sa[1] = 5;  sb[1] = 6;
    sa[2] = -3; sb[2] = 7;
    begin_run(3);
    feed(3, 0, dropped);
    collect("t2_sum", 0, 0);

    // Same samples with 2-cycle gaps.
    begin_run(3);
    feed(3, 2, dropped);
    check("t3_ready_held", dropped, 0);
    collect("t3_sum", 0, 0);

    // Result stall with START mid-stall and at the handshake: 12 - 10 = 2.
    sa[0] = 3;  sb[0] = 4;
    sa[1] = -2; sb[1] = 5;
    begin_run(2);
    feed(2, 0, dropped);
    collect("t4_sum", 5, 1);
    step();
    check("t4_start_ignored", busy, 0);

    // Reset after 2 of 4 samples.
    sa[0] = 1; sb[0] = 2;
    sa[1] = 3; sb[1] = 4;
    sa[2] = 5; sb[2] = 6;
    sa[3] = 7; sb[3] = 8;
    begin_run(4);
    feed(2, 0, dropped);
    s_valid = 1'b1; s_a = 18'sd9; s_b = 18'sd9;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    exp_q.delete();
    s_valid = 1'b0; s_a = '0; s_b = '0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 3; i++) step();
    check("t5_no_result", r_valid, 0);
    sa[0] = 7; sb[0] = -8;
    begin_run(1);
    feed(1, 0, dropped);
    collect("t5_sum", 0, 0);

    // START with LEN=0 is ignored.
    start = 1'b1;
    len   = 8'd0;
    step();
    start = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_s_ready", s_ready, 0);
    step();
    check("t6_busy_later", busy, 0);
    check("t6_ce", dsp_ce, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dsp_mac_seq

// File: doc/dsp_mac_seq.md
DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Interface
REQ-001 Parameter DSP_LAT, default 3, SHALL be the cycles from operands on DSP_A/DSP_B to the DSP48A1 P output reflecting them (A1REG=B1REG=MREG=PREG=1).
REQ-002 Parameter OPM_DLY, default 1, SHALL be the cycles DSP_OPMODE lags its operands (the OPMODE register is one stage; the operand path is two stages).
REQ-003 CLK  in  1  single clock; all flops on rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 START  in  1  one-cycle request to begin a dot product.
REQ-006 LEN  in  8  number of sample pairs, sampled on an accepted START.
REQ-007 S_VALID/S_READY  in/out  1/1  sample handshake; S_A, S_B in 18 signed operands.
REQ-008 DSP_A, DSP_B  out  18  operands to the DSP48A1 A/B ports.
REQ-009 DSP_OPMODE  out  8  DSP48A1 opmode.
REQ-010 DSP_CE  out  1  common clock enable for all DSP registers.
REQ-011 DSP_RST  out  1  common active-high reset for all DSP registers.
REQ-012 DSP_P  in  48  DSP48A1 P output.
REQ-013 R_VALID/R_READY  out/in  1/1  result handshake; R_DATA out 48 signed sum.
REQ-014 BUSY  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN, DRAIN, and DONE.
REQ-016 IDLE->RUN SHALL occur on START=1 with LEN!=0; START with LEN=0, or START outside IDLE, SHALL be ignored.
REQ-017 In RUN, S_READY SHALL be 1, and a sample SHALL be accepted when S_VALID&S_READY, decrementing the remaining count.
REQ-018 An accepted sample SHALL be driven on DSP_A/DSP_B in that cycle, with opmode LOAD (8'h01, P=A*B) for the first sample and ACC (8'h09, P=P+A*B) for later samples, each delayed OPM_DLY cycles.
REQ-019 A RUN cycle without acceptance SHALL drive DSP_A=DSP_B=0; after the first sample its opmode SHALL be ACC (adds zero), and before it the opmode SHALL be don't-care.
REQ-020 On acceptance of the last sample, the FSM SHALL enter DRAIN, drop S_READY, and load the drain counter with DSP_LAT.
REQ-021 In DRAIN, the block SHALL drive DSP_A=DSP_B=0 with ACC opmode, and when the counter reaches 0 it SHALL capture DSP_P into R_DATA and enter DONE.
REQ-022 In DONE, R_VALID SHALL be 1 and R_DATA SHALL be stable; on R_VALID&R_READY the FSM SHALL go to IDLE.
REQ-023 DSP_CE SHALL be 1 outside IDLE; DSP_RST SHALL be 1 in IDLE and 0 otherwise.
REQ-024 The sum SHALL be a 48-bit two's-complement value; 255 full-scale 36-bit products fit, so no overflow flag is required.
REQ-025 A START arriving in the same cycle as a DONE handshake SHALL be ignored.

Reset
REQ-026 RST_N low SHALL asynchronously force: state IDLE; counters 0; S_READY=0; R_VALID=0; R_DATA=0; DSP_A=DSP_B=0; DSP_OPMODE=0; DSP_CE=0; DSP_RST=1; BUSY=0.
REQ-027 Reset in any state SHALL abandon the operation without producing a result.

Structure
REQ-028 Package dsp_mac_pkg SHALL hold the state enum, OPM_LOAD=8'h01, OPM_ACC=8'h09, and the default latencies.
REQ-029 The opmode delay line SHALL be the sub-module dsp_mac_dly (width and depth parameters, reset to 0).
REQ-030 The bench SHALL instantiate DSP48A1 as the responder with DSP_P fed back.

Verification
REQ-031 LEN=1, sample (5,6) -> R_VALID rises DSP_LAT+1 cycles after acceptance; R_DATA=30.
REQ-032 LEN=3, samples (20,10),(5,6),(-3,7) back-to-back -> R_DATA=209.
REQ-033 LEN=3, same samples with 2-cycle S_VALID gaps -> R_DATA=209 and S_READY stays 1 throughout RUN.
REQ-034 R_READY held 0 for 5 cycles in DONE, with a START pulse in between -> R_DATA stable, START ignored, IDLE after R_READY=1.
REQ-035 RST_N low mid-RUN after 2 of 4 samples -> all outputs at reset values immediately; a following LEN=1 (7,-8) run -> R_DATA=-56.
REQ-036 START with LEN=0 -> BUSY stays 0; S_READY stays 0.
